// File: rtl/data_register.sv
// Generic single-word holding register: load-enable, synchronous clear,
// asynchronous active-low reset to RESET_VALUE. Output comes straight from the flop.
`ifndef BITWIDTH
`define BITWIDTH 16
`endif

module data_register #(
    parameter int                   BITWIDTH    = `BITWIDTH,
    parameter logic [BITWIDTH-1:0]  RESET_VALUE = {BITWIDTH{1'b0}}
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic [BITWIDTH-1:0] iData,
    output logic [BITWIDTH-1:0] oData
);

    logic [BITWIDTH-1:0] q_r;
    logic [BITWIDTH-1:0] q_next_s;

    // Next-state selection: clear outranks load, otherwise hold.
    always_comb begin
        q_next_s = q_r;
        if (iClr) begin
            q_next_s = {BITWIDTH{1'b0}};
        end else if (iEn) begin
            q_next_s = iData;
        end else begin
            q_next_s = q_r;
        end
    end

    // State register with asynchronous reset overriding any pending clear or load.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign oData = q_r;

endmodule

// File: tb/tb_data_register.sv
// Directed, scoreboard-based bench for data_register: expected words are queued
// as stimulus is applied and compared after the capturing edge.
`ifndef BITWIDTH
`define BITWIDTH 16
`endif

module tb_data_register;

    localparam int W = `BITWIDTH;

    logic         iClk;
    logic         iRstN;
    logic         iEn;
    logic         iClr;
    logic [W-1:0] iData;
    logic [W-1:0] oData;

    logic [W-1:0] model_q;
    logic [W-1:0] exp_q[$];
    int           checks;
    int           errors;

    data_register #(.BITWIDTH(W), .RESET_VALUE({W{1'b0}})) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (iEn),
        .iClr  (iClr),
        .iData (iData),
        .oData (oData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic compare(input string tag, input logic [W-1:0] expected);
        checks++;
        assert (oData === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, oData, expected);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty-scoreboard expected queued value", tag);
        end else begin
            e = exp_q.pop_front();
            compare(tag, e);
        end
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic step(input logic en, input logic clr, input logic [W-1:0] data, input string tag);
        iEn   = en;
        iClr  = clr;
        iData = data;
        if (clr)     model_q = {W{1'b0}};
        else if (en) model_q = data;
        else         model_q = model_q;
        exp_q.push_back(model_q);
        @(posedge iClk);
        #1;
        check_pop(tag);
    endtask

    initial begin
        logic [W-1:0] all_ones;
        logic [W-1:0] msb_only;
        checks   = 0;
        errors   = 0;
        all_ones = {W{1'b1}};
        msb_only = {W{1'b0}};
        msb_only[W-1] = 1'b1;

        // Reset held over several edges with load requested.
        iRstN = 1'b0; iEn = 1'b1; iClr = 1'b0; iData = {W{1'b0}};
        model_q = {W{1'b0}};
        #1;
        compare("reset_immediate", {W{1'b0}});
        for (int i = 0; i < 3; i++) begin
            @(posedge iClk); #1;
            compare("reset_held", {W{1'b0}});
        end
        iData = 16'hABCD;
        @(posedge iClk); #1;
        compare("reset_ignores_data", {W{1'b0}});
        @(negedge iClk);
        iRstN = 1'b1;
        #1;
        compare("reset_release_mid", {W{1'b0}});

        // Sequential loads.
        step(1'b1, 1'b0, 16'd10,    "load_10");
        step(1'b1, 1'b0, 16'd100,   "load_100");
        step(1'b1, 1'b0, 16'd1000,  "load_1000");
        step(1'b1, 1'b0, 16'd10000, "load_10000");

        // Clear with enable high, held for 40 edges.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 16'h5A5A ^ 16'(i), "clear_held");
        end

        // Hold with random data and enable low.
        step(1'b1, 1'b0, 16'h1234, "load_1234");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, W'($urandom), "hold_1234");
        end

        // Clear without enable, then hold at zero until next load.
        step(1'b1, 1'b0, all_ones, "load_all_ones");
        step(1'b0, 1'b1, all_ones, "clear_no_en");
        step(1'b0, 1'b0, 16'h7777, "hold_after_clear");
        step(1'b0, 1'b0, 16'h1111, "hold_after_clear");
        step(1'b1, 1'b0, 16'h00AA, "load_after_clear");

        // Width boundary.
        step(1'b1, 1'b0, all_ones,     "width_all_ones");
        step(1'b1, 1'b0, {W{1'b0}},    "width_zero");
        step(1'b1, 1'b0, msb_only,     "width_msb");

        // Asynchronous reset mid-cycle after a load.
        step(1'b1, 1'b0, 16'h5555, "load_before_reset");
        #2;
        iRstN = 1'b0;
        #1;
        compare("async_reset_mid", {W{1'b0}});
        @(posedge iClk); #1;
        compare("async_reset_held", {W{1'b0}});
        @(negedge iClk);
        iRstN = 1'b1;
        model_q = {W{1'b0}};
        step(1'b0, 1'b0, 16'h3333, "hold_after_reset");
        step(1'b1, 1'b0, 16'h3333, "load_after_reset");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_register.md
# data_register

Parameterized-width storage register with synchronous load-enable and synchronous clear, plus asynchronous active-low reset. It is the generic state-holding element of the datapath: it captures a word when enabled, zeroes itself on request, and presents the stored value continuously. Instances appear wherever a pipeline stage, accumulator or held operand needs a single-word holding register.

## Interface

- BITWIDTH, default 16: data width in bits; supplied as the `BITWIDTH` compile-time define; legal range 1..64.
- RESET_VALUE, default 0: value loaded by reset; must fit in BITWIDTH bits.

Ports:

- iClk  input  1  clock; all state changes on rising edge except reset.
- iRstN  input  1  reset; one clock; asynchronous, active-low.
- iEn  input  1  load enable; active-high.
- iClr  input  1  synchronous clear; active-high.
- iData  input  BITWIDTH  data word to load.
- oData  output  BITWIDTH  stored value, driven directly from the register with no combinational path from any input.

## Operation

- Internal state: one BITWIDTH-bit register `q`; oData = q at all times.
- Priority per rising edge, highest first:
  - iRstN low: q = RESET_VALUE, applied asynchronously.
  - iClr high: q = 0, regardless of iEn or iData.
  - iEn high: q = iData.
  - Otherwise: q holds its value.
- Clear is not enable-gated; iClr=1 with iEn=0 still zeroes q.
- iData is loaded verbatim: no arithmetic, truncation or sign handling. Width is exactly BITWIDTH.
- No X-propagation masking. Inputs must be known at sampling edges.

## Timing

- Reset assertion: oData = RESET_VALUE immediately, without waiting for a clock edge, and stays there while iRstN is low. Clock edges during reset are ignored.
- Reset release: the first rising edge after iRstN goes high performs normal clear/load/hold evaluation. Deassertion must meet recovery/removal timing relative to iClk.
- Load latency is 1 cycle: iData sampled at edge N appears on oData right after edge N and remains until the next qualifying edge.
- Clear latency is 1 cycle. oData stays 0 on every edge while iClr is held high.
- Reset asserted mid-operation overrides any pending clear or load at once.
- Simultaneous iClr=1 and iEn=1: clear wins, so oData = 0.
- Inputs are sampled only at rising edges. Changes between edges have no effect on oData.

## Test plan

- Reset: iRstN=0 with iEn=1 and iData=0, clocking; release at a mid-cycle point -> oData=0 throughout reset. Asserting iRstN mid-cycle after a load forces oData=0 before the next edge.
- Sequential load: with iEn=1, drive iData 10, 100, 1000, 10000 on successive cycles -> oData follows each value exactly one edge later (10, 100, 1000, 10000).
- Hold: load 0x1234, then set iEn=0 and toggle iData randomly for 5 cycles -> oData stays 0x1234.
- Clear: after oData=10000, set iClr=1 with iEn=1 and hold for 40 cycles -> oData=0 from the first edge and stays 0 for all 40 cycles.
- Clear without enable: load 0xFFFF (all ones), then iEn=0 and iClr=1 for one edge -> oData=0. Deassert iClr -> oData holds 0 until the next enabled load.
- Width boundary: with iEn=1 load all-ones, then 0, then 0x8000 -> oData matches bit-exactly at each edge, with no truncation of the MSB.
